// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with one-entry skid buffer, valid/ready handshake and synchronous flush.
// Optional statistics counters (stall_cycles, xfer_count) are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_elastic #(
   parameter int unsigned        WIDTH      = 16,
   parameter logic [WIDTH-1:0]   BUBBLE_VAL = {WIDTH{1'b0}},
   parameter int unsigned        COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [COUNT_W-1:0] stall_cycles,
   output logic [COUNT_W-1:0] xfer_count
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   main_q, main_d;
   logic [WIDTH-1:0]   skid_q, skid_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic [1:0]         occ_q, occ_d;
   logic               take_c;
   logic               accept_c;

   assign take_c   = out_valid_q && out_ready;
   assign accept_c = in_valid && in_ready_q;

   // Next-state and next-output decode; flush squashes everything after the handshake decode.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept_c) begin
               state_d = ST_FULL;
               main_d  = in_data;
            end
         end
         ST_FULL: begin
            if (take_c && accept_c) begin
               main_d = in_data;
            end else if (take_c) begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE_VAL;
            end else if (accept_c) begin
               state_d = ST_SKID;
               skid_d  = in_data;
            end
         end
         ST_SKID: begin
            if (take_c) begin
               state_d = ST_FULL;
               main_d  = skid_q;
               skid_d  = BUBBLE_VAL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
         end
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_SKID);
      occ_d       = (state_d == ST_SKID) ? 2'd2 : ((state_d == ST_FULL) ? 2'd1 : 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= BUBBLE_VAL;
         skid_q      <= BUBBLE_VAL;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         occ_q       <= occ_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign in_ready  = in_ready_q;
   assign occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
   logic [COUNT_W-1:0] stall_q, stall_d;
   logic [COUNT_W-1:0] xfer_q, xfer_d;

   // Saturating counters; cleared by reset only, flush leaves them running.
   always_comb begin
      stall_d = stall_q;
      xfer_d  = xfer_q;
      if (out_valid_q && !out_ready && (stall_q != {COUNT_W{1'b1}})) begin
         stall_d = stall_q + COUNT_W'(1);
      end
      if (take_c && (xfer_q != {COUNT_W{1'b1}})) begin
         xfer_d = xfer_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         xfer_q  <= '0;
      end else begin
         stall_q <= stall_d;
         xfer_q  <= xfer_d;
      end
   end

   assign stall_cycles = stall_q;
   assign xfer_count   = xfer_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_STATS_EN
   localparam int unsigned CW = 4;
`else
   localparam int unsigned CW = 16;
`endif
   localparam int unsigned MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [15:0]   in_data;
   logic          in_ready, out_valid;
   logic [15:0]   out_data;
   logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
   logic [CW-1:0] stall_cycles, xfer_count;
`endif

   int errors = 0;
   int checks = 0;

   logic [15:0] mq[$];
   int stall_m = 0;
   int xfer_m  = 0;

   pipe_stage_elastic #(.WIDTH(16), .BUBBLE_VAL(16'h0000), .COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cycles(stall_cycles), .xfer_count(xfer_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic exp_valid();
      return mq.size() > 0;
   endfunction
   function automatic logic [15:0] exp_data();
      return (mq.size() > 0) ? mq[0] : 16'h0000;
   endfunction
   function automatic logic exp_ready();
      return mq.size() < 2;
   endfunction
   function automatic logic [1:0] exp_occ();
      return 2'(mq.size());
   endfunction

   // Advance one clock and apply the FIFO-of-two model to the inputs present at the edge.
   task automatic tick();
      bit take, acc;
      take = (mq.size() > 0) && out_ready;
      acc  = in_valid && (mq.size() < 2);
      @(posedge clk);
      if (rst) begin
         mq.delete();
         stall_m = 0;
         xfer_m  = 0;
      end else begin
         if ((mq.size() > 0) && !out_ready && stall_m < MAXC) stall_m++;
         if (take && xfer_m < MAXC) xfer_m++;
         if (flush) mq.delete();
         else begin
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
      checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h want=0000", out_data); end
   endtask

   task automatic test_streaming();
      logic [15:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vals[i];
         tick();
         checks++; if (out_data !== vals[i]) begin errors++; $display("FAIL stream_data[%0d] got=%h want=%h", i, out_data, vals[i]); end
         checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stream_ctl[%0d] got occ=%0d rdy=%b vld=%b want occ=1 rdy=1 vld=1", i, occupancy, in_ready, out_valid); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
         errors++; $display("FAIL stream_drain got vld=%b data=%h want vld=0 data=0000", out_valid, out_data); end
   endtask

   task automatic test_stall_skid();
      logic [15:0] want [3] = '{16'hBBBB, 16'hCCCC, 16'h0000};
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'hAAAA; tick();
      in_data = 16'hBBBB; tick();
      checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hAAAA) begin
         errors++; $display("FAIL skid_fill got occ=%0d rdy=%b data=%h want occ=2 rdy=0 data=aaaa", occupancy, in_ready, out_data); end
      in_data = 16'hCCCC; tick(); tick();
      checks++; if (occupancy !== 2'd2 || out_data !== 16'hAAAA) begin
         errors++; $display("FAIL skid_hold got occ=%0d data=%h want occ=2 data=aaaa", occupancy, out_data); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 1) in_valid = 1'b0;
         checks++; if (out_data !== want[i] || out_data !== exp_data()) begin
            errors++; $display("FAIL skid_drain[%0d] got=%h want=%h", i, out_data, want[i]); end
         if (i == 0) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready got=%b want=1", in_ready); end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 16'h1234; tick();
      in_data = 16'h5678; tick();
      flush = 1'b1; in_data = 16'h5555; tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_state got vld=%b occ=%0d data=%h rdy=%b want 0/0/0000/1", out_valid, occupancy, out_data, in_ready); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_data === 16'h5555 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_leak[%0d] got vld=%b data=%h want vld=0 data!=5555", i, out_valid, out_data); end
      end
   endtask

   task automatic test_reset_priority();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h7777; tick();
      in_data = 16'h8888; rst = 1'b1; flush = 1'b1; tick();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 16'h0000) begin
         errors++; $display("FAIL rst_prio got vld=%b rdy=%b occ=%0d data=%h want 0/1/0/0000", out_valid, in_ready, occupancy, out_data); end
`ifdef PIPE_STAGE_STATS_EN
      checks++; if (stall_cycles !== '0 || xfer_count !== '0) begin
         errors++; $display("FAIL rst_stats got stall=%0d xfer=%0d want 0/0", stall_cycles, xfer_count); end
`endif
   endtask

`ifdef PIPE_STAGE_STATS_EN
   task automatic test_stats();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h4242; tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      checks++; if (stall_cycles !== 4'hF) begin errors++; $display("FAIL stats_sat got=%h want=f", stall_cycles); end
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0001; tick();
      in_data = 16'h0002; tick();
      in_valid = 1'b0; tick();
      checks++; if (xfer_count !== 4'd3) begin errors++; $display("FAIL stats_xfer got=%0d want=3", xfer_count); end
      flush = 1'b1; tick(); flush = 1'b0;
      checks++; if (stall_cycles !== 4'hF || xfer_count !== 4'd3) begin
         errors++; $display("FAIL stats_flush got stall=%h xfer=%0d want f/3", stall_cycles, xfer_count); end
   endtask
`endif

   task automatic test_random();
      rst = 1'b1; tick(); rst = 1'b0;
      in_valid = 1'b0; in_data = 16'h0;
      for (int i = 0; i < 400; i++) begin
         // A compliant upstream holds its payload until accepted.
         if (!(in_valid && !in_ready)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         tick();
         checks++; if (out_valid !== exp_valid() || out_data !== exp_data() || in_ready !== exp_ready() || occupancy !== exp_occ()) begin
            errors++; $display("FAIL rand[%0d] got vld=%b data=%h rdy=%b occ=%0d want vld=%b data=%h rdy=%b occ=%0d",
               i, out_valid, out_data, in_ready, occupancy, exp_valid(), exp_data(), exp_ready(), exp_occ()); end
`ifdef PIPE_STAGE_STATS_EN
         checks++; if (stall_cycles !== CW'(stall_m) || xfer_count !== CW'(xfer_m)) begin
            errors++; $display("FAIL rand_stats[%0d] got stall=%0d xfer=%0d want %0d/%0d", i, stall_cycles, xfer_count, stall_m, xfer_m); end
`endif
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall_skid();
      test_flush();
      test_reset_priority();
`ifdef PIPE_STAGE_STATS_EN
      test_stats();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
